// File: rtl/fsmd_job_scheduler_pkg.sv
// fsmd_job_scheduler: shared package
// State encoding and operand field slots within one request slice.
package fsmd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int NF    = 5;
  localparam int OFF_A = 0;
  localparam int OFF_B = 1;
  localparam int OFF_C = 2;
  localparam int OFF_D = 3;
  localparam int OFF_E = 4;

endpackage

// File: rtl/fsmd_job_scheduler_if.sv
// fsmd_job_scheduler: request/result handshake bundle
// master = clients and consumer side, slave = scheduler side.
interface fsmd_job_scheduler_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*5*W-1:0] req_data;
  logic             res_valid;
  logic             res_ready;
  logic [IDW-1:0]   res_id;
  logic [W-1:0]     res_r1;
  logic [W-1:0]     res_r2;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id,
    input  res_r1, res_r2
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id,
    output res_r1, res_r2
  );

endinterface

// File: rtl/fsmd_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps N-1 -> 0.
// Purely combinational one-hot grant plus grant index.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  int idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsmd_job_scheduler.sv
// Shared add/multiply FSMD serving N requesters round-robin.
// Result pair held on the result port until the consumer takes it.
module fsmd_job_scheduler
  import fsmd_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  fsmd_job_scheduler_if.slave   bus,
  output logic                  busy,
  output logic [2:0]            step
);

  localparam int IDW = $clog2(N);
  localparam int SL  = NF * W;

  state_t         state;
  state_t         nxt;
  logic [SL-1:0]  ops;
  logic [W-1:0]   r1, r2, r3;
  logic [W-1:0]   add_a, add_b;
  logic [W-1:0]   mul_a, mul_b;
  logic [W-1:0]   sum, prod;
  logic [W-1:0]   op_a, op_b, op_c;
  logic [W-1:0]   op_d, op_e;
  logic [IDW-1:0] ptr, id_q, gnt_id;
  logic [N-1:0]   gnt;
  logic           any;
  logic           done;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign op_a = ops[OFF_A*W +: W];
  assign op_b = ops[OFF_B*W +: W];
  assign op_c = ops[OFF_C*W +: W];
  assign op_d = ops[OFF_D*W +: W];
  assign op_e = ops[OFF_E*W +: W];

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (any) nxt = S0;
      S0:      nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = S3;
      S3:      nxt = S4;
      S4:      nxt = DONE;
      DONE:    if (bus.res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // One adder and one multiplier, steered per step.
  always_comb begin
    add_a = '0;
    add_b = '0;
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      S1: begin
        add_a = r1;
        add_b = r2;
      end
      S2: begin
        add_a = r2;
        add_b = r3;
      end
      S3: begin
        add_a = r1;
        add_b = r3;
        mul_a = r1;
        mul_b = r2;
      end
      S4: begin
        mul_a = r1;
        mul_b = r3;
      end
      default: ;
    endcase
  end

  assign sum  = add_a + add_b;
  assign prod = mul_a * mul_b;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ops  <= '0;
      id_q <= '0;
      ptr  <= '0;
      r1   <= '0;
      r2   <= '0;
      r3   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            ops  <= bus.req_data[int'(gnt_id)*SL +: SL];
            id_q <= gnt_id;
            ptr  <= (int'(gnt_id) == N - 1) ? '0
                                            : gnt_id + 1'b1;
          end
        end
        S0: begin
          r1 <= op_a;
          r2 <= op_c;
        end
        S1: begin
          r1 <= sum;
          r3 <= op_d;
        end
        S2: begin
          r2 <= sum;
          r3 <= op_b;
        end
        S3: begin
          r1 <= sum;
          r2 <= prod;
          r3 <= op_e;
        end
        S4: r1 <= prod;
        default: ;
      endcase
    end
  end

  assign done          = (state == DONE);
  assign bus.req_ready = (state == IDLE && reset) ? gnt : '0;
  assign bus.res_valid = done;
  assign bus.res_id    = done ? id_q : '0;
  assign bus.res_r1    = done ? r1 : '0;
  assign bus.res_r2    = done ? r2 : '0;
  assign busy          = (state != IDLE);
  assign step          = state;

endmodule

// File: tb/tb_fsmd_job_scheduler.sv
// Bench for fsmd_job_scheduler: vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_fsmd_job_scheduler;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int SL  = 5 * W;
  localparam int MOD = 1 << W;

  typedef struct {
    int id;
    int a;
    int b;
    int c;
    int d;
    int e;
    int r1;
    int r2;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [2:0] step;
  int n_run = 0;
  int n_fail = 0;
  int cyc_n = 0;

  fsmd_job_scheduler_if #(.N(N), .W(W)) bus ();

  fsmd_job_scheduler #(.N(N), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy),
    .step  (step)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  function automatic logic [SL-1:0] pack(input int a, b, c, d, e);
    return {W'(e), W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic int fld(input logic [SL-1:0] d, input int k);
    logic [SL-1:0] s;
    s = d >> (k * W);
    return int'(s) % MOD;
  endfunction

  function automatic int ref_r1(input int a, b, c, e);
    return ((a + b + c) * e) % MOD;
  endfunction

  function automatic int ref_r2(input int a, c, d);
    return ((a + c) * (c + d)) % MOD;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int id, input logic [SL-1:0] d);
    bus.req_data[id*SL +: SL] = d;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.res_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_r1", bus.res_r1, 0);
    chk("rst_r2", bus.res_r2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    reset = 1'b1;
    cyc();
  endtask

  task automatic wait_grant(input int id, output int ok);
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.req_ready[id]) begin
        ok = 1;
        return;
      end
      cyc();
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.res_valid) return;
      cyc();
      lat++;
    end
  endtask

  initial begin
    vec_t tbl[6];
    int ok, lat, ng, seen3, pick, acc;
    int gids[8];
    int gcyc[8];
    logic [SL-1:0] dat[N];
    int m_idle, m_age, m_ptr, m_id, m_r1, m_r2;

    tbl[0] = '{0, 1, 2, 3, 4, 5, 14, 12};
    tbl[1] = '{1, 15, 15, 15, 15, 15, 3, 4};
    tbl[2] = '{3, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{2, 2, 3, 1, 7, 9, 6, 8};
    tbl[4] = '{3, 7, 0, 8, 1, 3, 13, 7};
    tbl[5] = '{1, 10, 5, 6, 9, 2, 10, 0};

    // Vector table: single requester, latency and arithmetic.
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].id, pack(tbl[i].a, tbl[i].b, tbl[i].c,
                              tbl[i].d, tbl[i].e));
      wait_grant(tbl[i].id, ok);
      chk("tbl_grant", ok, 1);
      cyc();
      bus.req_valid = '0;
      wait_result(lat);
      chk("tbl_latency", lat, 6);
      chk("tbl_r1", bus.res_r1, tbl[i].r1);
      chk("tbl_r2", bus.res_r2, tbl[i].r2);
      chk("tbl_id", bus.res_id, tbl[i].id);
      cyc();
    end

    // All four held: order 0,1,2,3,0 at 7-cycle spacing.
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, pack(i + 1, i, 2 * i, 3, i + 5));
    ng = 0;
    for (int j = 0; j < 8; j++) begin
      gids[j] = -1;
      gcyc[j] = 0;
    end
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.req_ready != '0 && ng < 8) begin
        for (int j = 0; j < N; j++)
          if (bus.req_ready[j]) gids[ng] = j;
        gcyc[ng] = cyc_n;
        ng++;
      end
      cyc();
    end
    chk("rr_count", ng >= 5, 1);
    for (int j = 0; j < 5; j++) chk("rr_order", gids[j], j % N);
    for (int j = 1; j < 5; j++) chk("rr_gap", gcyc[j] - gcyc[j-1], 7);

    // Consumer stall in DONE for three cycles.
    do_reset();
    bus.res_ready = 1'b0;
    set_req(0, pack(1, 2, 3, 4, 5));
    wait_grant(0, ok);
    chk("stall_grant", ok, 1);
    cyc();
    bus.req_valid = '0;
    set_req(1, pack(15, 15, 15, 15, 15));
    wait_result(lat);
    chk("stall_latency", lat, 6);
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", bus.res_valid, 1);
      chk("stall_r1", bus.res_r1, 14);
      chk("stall_r2", bus.res_r2, 12);
      chk("stall_id", bus.res_id, 0);
      chk("stall_ready", bus.req_ready, 0);
      cyc();
      #1;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("stall_valid4", bus.res_valid, 1);
    cyc();
    #1;
    chk("stall_idle", step, 0);
    chk("stall_novalid", bus.res_valid, 0);
    chk("stall_next", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    cyc();

    // Reset during S2, then pointer is back at 0.
    do_reset();
    bus.res_ready = 1'b1;
    set_req(2, pack(1, 1, 1, 1, 1));
    wait_grant(2, ok);
    chk("mid_grant", ok, 1);
    cyc();
    bus.req_valid = '0;
    cyc();
    cyc();
    #1;
    chk("mid_in_s2", step, 3);
    reset = 1'b0;
    set_req(1, pack(2, 2, 2, 2, 2));
    set_req(3, pack(3, 3, 3, 3, 3));
    cyc();
    chk("mid_step", step, 0);
    chk("mid_valid", bus.res_valid, 0);
    chk("mid_busy", busy, 0);
    reset = 1'b1;
    #1;
    chk("mid_ptr0", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    cyc();

    // Withdrawn request is never granted.
    do_reset();
    bus.res_ready = 1'b1;
    set_req(0, pack(3, 3, 3, 3, 3));
    wait_grant(0, ok);
    chk("drop_grant0", ok, 1);
    cyc();
    bus.req_valid = '0;
    set_req(2, pack(4, 4, 4, 4, 4));
    set_req(3, pack(5, 5, 5, 5, 5));
    cyc();
    cyc();
    bus.req_valid[2] = 1'b0;
    seen3 = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      chk("drop_onehot", $onehot0(bus.req_ready), 1);
      chk("drop_never2", bus.req_ready[2], 0);
      if (bus.req_ready[3]) seen3 = 1;
      cyc();
    end
    chk("drop_req3", seen3, 1);

    // Random traffic against the reference model.
    do_reset();
    bus.req_valid = '0;
    m_idle = 1;
    m_age = 0;
    m_ptr = 0;
    m_id = 0;
    m_r1 = 0;
    m_r2 = 0;
    acc = -1;
    for (int i = 0; i < N; i++) dat[i] = '0;
    for (int t = 0; t < 1500; t++) begin
      if (acc >= 0) bus.req_valid[acc] = 1'b0;
      acc = -1;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            dat[i] = SL'($urandom());
            set_req(i, dat[i]);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      #1;
      pick = m_idle ? rr_pick(bus.req_valid, m_ptr) : -1;
      chk("rnd_ready", bus.req_ready, pick >= 0 ? (1 << pick) : 0);
      chk("rnd_valid", bus.res_valid, m_age == 6);
      chk("rnd_busy", busy, !m_idle);
      chk("rnd_step", step, m_age);
      if (m_age == 6) begin
        chk("rnd_r1", bus.res_r1, m_r1);
        chk("rnd_r2", bus.res_r2, m_r2);
        chk("rnd_id", bus.res_id, m_id);
      end
      if (m_idle && pick >= 0) begin
        m_r1 = ref_r1(fld(dat[pick], 0), fld(dat[pick], 1),
                      fld(dat[pick], 2), fld(dat[pick], 4));
        m_r2 = ref_r2(fld(dat[pick], 0), fld(dat[pick], 2),
                      fld(dat[pick], 3));
        m_id = pick;
        m_ptr = (pick + 1) % N;
        m_idle = 0;
        m_age = 1;
        acc = pick;
      end else if (!m_idle && m_age < 6) begin
        m_age++;
      end else if (m_age == 6 && bus.res_ready) begin
        m_idle = 1;
        m_age = 0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
